// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core: hazard FSM state encoding,
// default widths and the stage-register control levels used for NOP insertion.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } hcu_state_e;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int MC_CNT_W_DEF   = 4;

    // Stage-register control levels: a held register keeps its instruction,
    // an inserted NOP replaces it with a bubble.
    localparam logic STAGE_HOLD    = 1'b0;
    localparam logic STAGE_ADVANCE = 1'b1;
    localparam logic NOP_INSERT    = 1'b1;
    localparam logic NOP_NONE      = 1'b0;

endpackage

// File: rtl/mc_latency_counter.sv
// Down-counter tracking the remaining cycles of a multi-cycle EX operation.
// Decrement saturates at zero so the count can never wrap.
module mc_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_one_left
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_one_left = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle EX freezes. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_control_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MC_CNT_W   = MC_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mc_start,
    input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mc_busy,
    output logic                  mc_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    hcu_state_e          r_state;
    hcu_state_e          w_nextState;
    logic                w_loadUse;
    logic                w_evalHazards;
    logic                w_cntLoad;
    logic                w_cntDec;
    logic                w_cntOneLeft;
    logic [MC_CNT_W-1:0] w_cnt;
    logic [MC_CNT_W-1:0] w_mcLoadVal;

    assign w_loadUse = id_ex_mem_read && (id_ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // A latency of zero is treated as one, so the loaded remainder is max(N,1)-1.
    assign w_mcLoadVal = (ex_mc_cycles == '0) ? '0 : (ex_mc_cycles - 1'b1);

    mc_latency_counter #(
        .CNT_W(MC_CNT_W)
    ) u_mc_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_cntLoad),
        .i_load_val(w_mcLoadVal),
        .i_dec     (w_cntDec),
        .o_cnt     (w_cnt),
        .o_one_left(w_cntOneLeft)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_evalHazards  = 1'b0;
        w_cntLoad      = 1'b0;
        w_cntDec       = 1'b0;
        pc_write_en    = STAGE_ADVANCE;
        if_id_write_en = STAGE_ADVANCE;
        id_ex_write_en = STAGE_ADVANCE;
        if_id_flush    = NOP_NONE;
        id_ex_bubble   = NOP_NONE;
        ex_mem_bubble  = NOP_NONE;
        mc_busy        = 1'b0;
        mc_done        = 1'b0;

        unique case (r_state)
            RUN: begin
                if (ex_mc_start) begin
                    pc_write_en    = STAGE_HOLD;
                    if_id_write_en = STAGE_HOLD;
                    id_ex_write_en = STAGE_HOLD;
                    ex_mem_bubble  = NOP_INSERT;
                    w_cntLoad      = 1'b1;
                    w_nextState    = (w_mcLoadVal != '0) ? MC_BUSY : MC_DONE;
                end else begin
                    w_evalHazards = 1'b1;
                end
            end
            MC_BUSY: begin
                pc_write_en    = STAGE_HOLD;
                if_id_write_en = STAGE_HOLD;
                id_ex_write_en = STAGE_HOLD;
                ex_mem_bubble  = NOP_INSERT;
                mc_busy        = 1'b1;
                w_cntDec       = 1'b1;
                // cnt==0 here is unreachable; leaving anyway avoids a lockup.
                if (w_cntOneLeft || (w_cnt == '0)) begin
                    w_nextState = MC_DONE;
                end
            end
            MC_DONE: begin
                mc_done       = 1'b1;
                w_evalHazards = 1'b1;
                w_nextState   = RUN;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase

        // A taken branch wins over a load-use stall: the stalled instruction is discarded.
        if (w_evalHazards) begin
            if (ex_branch_taken) begin
                if_id_flush  = NOP_INSERT;
                id_ex_bubble = NOP_INSERT;
                pc_write_en  = STAGE_ADVANCE;
            end else if (w_loadUse) begin
                pc_write_en    = STAGE_HOLD;
                if_id_write_en = STAGE_HOLD;
                id_ex_bubble   = NOP_INSERT;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_flushCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (!pc_write_en && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (if_id_flush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus random
// stimulus against a cycle-budget reference model. HAZARD_PERF_CNT_EN adds counter checks.
module tb_hazard_control_unit;

    localparam int RW = 5;
    localparam int CW = 4;
    localparam logic [7:0] IDLE_OUT = 8'b1110_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, id_ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic          ex_branch_taken, ex_mc_start;
    logic [CW-1:0] ex_mc_cycles;
    logic          pc_write_en, if_id_write_en, id_ex_write_en;
    logic          if_id_flush, id_ex_bubble, ex_mem_bubble, mc_busy, mc_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count;
`endif

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: cycles of freeze still owed to the running op, and whether
    // the current cycle is the op's completion cycle.
    int     mFreezeLeft = 0;
    bit     mDoneNow    = 1'b0;
    longint mStalls     = 0;
    longint mFlushes    = 0;

    hazard_control_unit #(
        .REG_ADDR_W(RW),
        .MC_CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_cycles   (ex_mc_cycles),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .id_ex_write_en (id_ex_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_bubble  (ex_mem_bubble),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] observedVec();
        return {pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush,
                id_ex_bubble, ex_mem_bubble, mc_busy, mc_done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Expected outputs straight from the rules: freeze while the op owes cycles,
    // otherwise start-stall, branch flush, load-use stall or normal flow.
    function automatic logic [7:0] modelOutputs();
        bit loadUse;
        bit pcEn, ifEn, exEn, flush, idBub, memBub, busy, done;
        loadUse = id_ex_mem_read && (id_ex_rd != 0) &&
                  ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
        {pcEn, ifEn, exEn, flush, idBub, memBub, busy, done} = 8'b1110_0000;
        if (mFreezeLeft > 0) begin
            {pcEn, ifEn, exEn, memBub, busy} = 5'b00011;
        end else if (!mDoneNow && ex_mc_start) begin
            {pcEn, ifEn, exEn, memBub} = 4'b0001;
        end else begin
            done = mDoneNow;
            if (ex_branch_taken) begin
                flush = 1'b1;
                idBub = 1'b1;
            end else if (loadUse) begin
                pcEn  = 1'b0;
                ifEn  = 1'b0;
                idBub = 1'b1;
            end
        end
        return {pcEn, ifEn, exEn, flush, idBub, memBub, busy, done};
    endfunction

    function automatic void modelAdvance();
        int n;
        if (mFreezeLeft > 0) begin
            mFreezeLeft--;
            mDoneNow = (mFreezeLeft == 0);
        end else if (mDoneNow) begin
            mDoneNow = 1'b0;
        end else if (ex_mc_start) begin
            n           = (ex_mc_cycles == 0) ? 1 : int'(ex_mc_cycles);
            mFreezeLeft = n - 1;
            mDoneNow    = (mFreezeLeft == 0);
        end
    endfunction

    function automatic void modelReset();
        mFreezeLeft = 0;
        mDoneNow    = 1'b0;
        mStalls     = 0;
        mFlushes    = 0;
    endfunction

    task automatic applyStimulus(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                 input logic u1, input logic u2, input logic [RW-1:0] rd,
                                 input logic memRd, input logic br, input logic start,
                                 input logic [CW-1:0] cyc, input string tag);
        logic [7:0] e;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_rd = rd; id_ex_mem_read = memRd; ex_branch_taken = br;
        ex_mc_start = start; ex_mc_cycles = cyc;
        #1;
        e = modelOutputs();
        checkOutput(tag, {24'b0, observedVec()}, {24'b0, e});
        if (!e[7]) mStalls++;
        if (e[4]) mFlushes++;
        @(posedge clk);
        modelAdvance();
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, tag);
    endtask

    task automatic setIdleInputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_rd = '0; id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        setIdleInputs();
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("resetOutputs", {24'b0, observedVec()}, {24'b0, IDLE_OUT});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runMcOp(input logic [CW-1:0] n, input string tag);
        int hold;
        hold = ((n == 0) ? 1 : int'(n)) + 1;
        for (int i = 0; i < hold; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, n, tag);
        end
        idleCycle({tag, "Exit"});
    endtask

    initial begin
        setIdleInputs();
        rst = 1'b1;
        #12;
        checkOutput("resetInitial", {24'b0, observedVec()}, {24'b0, IDLE_OUT});
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, '0, "loadUseRs2");
        idleCycle("afterLoadUse");
        checkOutput("loadUseOneCycle", {31'b0, pc_write_en}, 32'd1);
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, '0, "loadUseRs1");
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, '0, "rdZeroNoStall");
        applyStimulus(5'd7, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, '0, "rs2UnusedNoStall");
        applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, '0, "branchOverLoadUse");

        runMcOp(4'd4, "mcFour");
        runMcOp(4'd0, "mcZero");
        runMcOp(4'd1, "mcOne");
        runMcOp(4'd15, "mcMax");
        // Branch and load-use arriving on the completion cycle are still honoured.
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd2, "mcDoneBranchA");
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd2, "mcDoneBranchB");
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd2, "mcDoneBranch");
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd1, "mcDoneLoadA");
        applyStimulus(5'd3, '0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 4'd1, "mcDoneLoadUse");
        idleCycle("mcDoneLoadExit");

`ifdef HAZARD_PERF_CNT_EN
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd2, '0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, '0, "perfLoadUse");
            idleCycle("perfIdle");
        end
        runMcOp(4'd4, "perfMc");
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, "perfBranch");
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, "perfBranch");
        #1;
        checkOutput("stallCyclesSeven", stall_cycles, 32'd7);
        checkOutput("flushCountTwo", flush_count, 32'd2);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), RW'($urandom_range(0, 3)),
                          1'($urandom), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 7) == 0), CW'($urandom_range(0, 6)), "random");
        end

`ifdef HAZARD_PERF_CNT_EN
        #1;
        checkOutput("stallCyclesModel", stall_cycles, 32'(mStalls));
        checkOutput("flushCountModel", flush_count, 32'(mFlushes));
`endif

        // Asynchronous reset between edges while a long op is mid-freeze.
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd8, "mcBeforeReset");
        end
        @(negedge clk);
        checkOutput("busyBeforeReset", {31'b0, mc_busy}, 32'd1);
        setIdleInputs();
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncResetOutputs", {24'b0, observedVec()}, {24'b0, IDLE_OUT});
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("asyncResetStalls", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idleCycle("afterResetIdle");
        runMcOp(4'd3, "mcAfterReset");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
